// File: rtl/ysyx_24100005_pkg.sv
// Shared types and constants for the ysyx_24100005 instruction fetch unit.
package ysyx_24100005_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } ifu_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_timer.sv
// Response timer for the fetch unit: clear-on-load, count-on-enable, saturating.
// Expiry is a threshold compare so a saturated count still reads as expired.
module ysyx_24100005_ifu_timer #(
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q >= CNT_LIMIT);

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one word per PC over a valid/ready memory bus.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
//
//  state | meaning
//  IDLE  | ready for a new PC
//  REQ   | request valid on imem, waiting for req_ready
//  WAIT  | request accepted, waiting for response or timeout
//  HOLD  | instruction (or fault) presented to core
//  DRAIN | flushed while a response is outstanding; swallow it
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_req_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [DATA_W-1:0] imem_resp_data_i,
    input  logic              imem_resp_err_i,
    output logic              imem_resp_ready_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              fetch_err_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
`endif
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;

    logic timer_load;
    logic timer_en;
    logic timer_expired;

    ysyx_24100005_ifu_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inst_pc_d  = inst_pc_q;
        inst_d     = inst_q;
        err_d      = err_q;
        timer_load = 1'b0;
        timer_en   = (state_q == WAIT) || (state_q == DRAIN);

        case (state_q)
            IDLE: begin
                if (pc_valid_i) begin
                    addr_d    = pc_i;
                    inst_pc_d = pc_i;
                    inst_d    = '0;
                    if (pc_misaligned(pc_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (imem_req_ready_i) begin
                    timer_load = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    // A response arriving with the flush is consumed right here.
                    state_d = imem_resp_valid_i ? IDLE : DRAIN;
                end else if (imem_resp_valid_i) begin
                    inst_d  = imem_resp_err_i ? '0 : imem_resp_data_i;
                    err_d   = imem_resp_err_i;
                    state_d = HOLD;
                end else if (timer_expired) begin
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush_i || inst_ready_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (imem_resp_valid_i || timer_expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            inst_pc_q <= '0;
            inst_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
        end
    end

    assign pc_ready_o        = (state_q == IDLE);
    assign imem_req_valid_o  = (state_q == REQ);
    assign imem_req_addr_o   = addr_q;
    assign imem_resp_ready_o = (state_q == WAIT) || (state_q == DRAIN);
    assign inst_valid_o      = (state_q == HOLD);
    assign inst_o            = inst_q;
    assign inst_pc_o         = inst_pc_q;
    assign fetch_err_o       = err_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == HOLD) && inst_ready_i) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if ((state_q == REQ) || (state_q == WAIT)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for ysyx_24100005_ifu (TIMEOUT_CYC=8); define IFU_PERF_CNT_EN to cover the counters.
module tb_ysyx_24100005_ifu;
    import ysyx_24100005_pkg::*;

    logic        clk;
    logic        rst;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        imem_resp_err_i;
    logic        imem_resp_ready_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fetch_err_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_24100005_ifu #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_valid_i        (pc_valid_i),
        .pc_i              (pc_i),
        .pc_ready_o        (pc_ready_o),
        .flush_i           (flush_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .imem_resp_err_i   (imem_resp_err_i),
        .imem_resp_ready_o (imem_resp_ready_o),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .fetch_err_o       (fetch_err_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_o      (perf_fetch_o),
        .perf_stall_o      (perf_stall_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a PC for one accepting edge; afterwards the DUT is in REQ or HOLD.
    task automatic accept_pc(input logic [31:0] pc);
        pc_valid_i = 1'b1;
        pc_i       = pc;
        step();
        pc_valid_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = data;
        imem_resp_err_i   = err;
        step();
        imem_resp_valid_i = 1'b0;
        imem_resp_err_i   = 1'b0;
    endtask

    task automatic consume();
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_valid_i = 1'b0;
        pc_i = '0;
        flush_i = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i = '0;
        imem_resp_err_i = 1'b0;
        inst_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        check_eq("rst_pc_ready", 32'(pc_ready_o), 32'd1);
        check_eq("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("rst_addr", imem_req_addr_o, 32'h0);
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_err", 32'(fetch_err_o), 32'd0);

        // Minimum-latency fetch: accept, REQ, WAIT with response, HOLD.
        imem_req_ready_i = 1'b1;
        accept_pc(RESET_PC);
        check_eq("t1_req_valid", 32'(imem_req_valid_o), 32'd1);
        check_eq("t1_req_addr", imem_req_addr_o, 32'h8000_0000);
        check_eq("t1_pc_ready_busy", 32'(pc_ready_o), 32'd0);
        step();
        imem_req_ready_i = 1'b0;
        check_eq("t1_wait_resp_ready", 32'(imem_resp_ready_o), 32'd1);
        check_eq("t1_wait_no_inst", 32'(inst_valid_o), 32'd0);
        respond(32'h0010_0093, 1'b0);
        check_eq("t1_inst_valid", 32'(inst_valid_o), 32'd1);
        check_eq("t1_inst", inst_o, 32'h0010_0093);
        check_eq("t1_inst_pc", inst_pc_o, 32'h8000_0000);
        check_eq("t1_err", 32'(fetch_err_o), 32'd0);
        step();
        check_eq("t1_hold_stable", 32'(inst_valid_o), 32'd1);
        check_eq("t1_hold_inst", inst_o, 32'h0010_0093);
        consume();
        check_eq("t1_back_idle", 32'(pc_ready_o), 32'd1);
        check_eq("t1_inst_drop", 32'(inst_valid_o), 32'd0);
`ifdef IFU_PERF_CNT_EN
        check_eq("t1_perf_fetch", perf_fetch_o, 32'd1);
        check_eq("t1_perf_stall", perf_stall_o, 32'd2);
`endif

        // Misaligned PC faults without touching memory.
        accept_pc(32'h8000_0002);
        check_eq("t2_no_req", 32'(imem_req_valid_o), 32'd0);
        check_eq("t2_inst_valid", 32'(inst_valid_o), 32'd1);
        check_eq("t2_err", 32'(fetch_err_o), 32'd1);
        check_eq("t2_inst_zero", inst_o, 32'h0);
        check_eq("t2_inst_pc", inst_pc_o, 32'h8000_0002);
        consume();

        // Back-pressure on the request channel for 4 cycles.
        accept_pc(32'h8000_0004);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_req_held%0d", i), 32'(imem_req_valid_o), 32'd1);
            check_eq($sformatf("t3_addr_stable%0d", i), imem_req_addr_o, 32'h8000_0004);
            step();
        end
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        check_eq("t3_wait", 32'(imem_resp_ready_o), 32'd1);
        respond(32'hDEAD_BEEF, 1'b0);
        check_eq("t3_inst", inst_o, 32'hDEAD_BEEF);
        check_eq("t3_inst_pc", inst_pc_o, 32'h8000_0004);
        consume();

        // Bus error response is reported as a fault with a zero word.
        imem_req_ready_i = 1'b1;
        accept_pc(32'h8000_0008);
        step();
        imem_req_ready_i = 1'b0;
        respond(32'h1234_5678, 1'b1);
        check_eq("t4_err", 32'(fetch_err_o), 32'd1);
        check_eq("t4_inst_zero", inst_o, 32'h0);
        consume();

        // Timeout after 8 WAIT cycles; stray response later is not accepted.
        imem_req_ready_i = 1'b1;
        accept_pc(32'h8000_0010);
        step();
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5_waiting%0d", i), 32'(inst_valid_o), 32'd0);
            step();
        end
        check_eq("t5_timeout_valid", 32'(inst_valid_o), 32'd1);
        check_eq("t5_timeout_err", 32'(fetch_err_o), 32'd1);
        check_eq("t5_timeout_inst", inst_o, 32'h0);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 32'hBAD0_BAD0;
        check_eq("t5_stray_not_ready", 32'(imem_resp_ready_o), 32'd0);
        consume();
        imem_resp_valid_i = 1'b0;
        check_eq("t5_idle_after", 32'(pc_ready_o), 32'd1);
        imem_req_ready_i = 1'b1;
        accept_pc(32'h8000_0014);
        step();
        imem_req_ready_i = 1'b0;
        respond(32'h00A0_0113, 1'b0);
        check_eq("t5_next_inst", inst_o, 32'h00A0_0113);
        check_eq("t5_next_err", 32'(fetch_err_o), 32'd0);
        consume();

        // Flush in WAIT, response two cycles later is drained.
        imem_req_ready_i = 1'b1;
        accept_pc(32'h8000_0020);
        step();
        imem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("t6_drain_ready", 32'(imem_resp_ready_o), 32'd1);
        check_eq("t6_drain_no_pc", 32'(pc_ready_o), 32'd0);
        step();
        check_eq("t6_drain_no_inst", 32'(inst_valid_o), 32'd0);
        respond(32'h0000_0073, 1'b0);
        check_eq("t6_idle_pc_ready", 32'(pc_ready_o), 32'd1);
        check_eq("t6_no_inst", 32'(inst_valid_o), 32'd0);
        check_eq("t6_resp_not_ready", 32'(imem_resp_ready_o), 32'd0);

        // Flush together with response in WAIT goes straight to IDLE.
        imem_req_ready_i = 1'b1;
        accept_pc(32'h8000_0024);
        step();
        imem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        respond(32'h0000_0013, 1'b0);
        flush_i = 1'b0;
        check_eq("t7_idle", 32'(pc_ready_o), 32'd1);
        check_eq("t7_no_inst", 32'(inst_valid_o), 32'd0);

        // Flush in REQ and in HOLD.
        accept_pc(32'h8000_0028);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("t8_req_flush_idle", 32'(pc_ready_o), 32'd1);
        check_eq("t8_req_flush_drop", 32'(imem_req_valid_o), 32'd0);
        accept_pc(32'h8000_0031);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_eq("t8_hold_flush_drop", 32'(inst_valid_o), 32'd0);
        check_eq("t8_hold_flush_idle", 32'(pc_ready_o), 32'd1);

        // Reset while holding an undelivered instruction.
        accept_pc(32'h8000_0033);
        check_eq("t9_in_hold", 32'(inst_valid_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t9_rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("t9_rst_pc_ready", 32'(pc_ready_o), 32'd1);
        check_eq("t9_rst_err", 32'(fetch_err_o), 32'd0);
        check_eq("t9_rst_inst_pc", inst_pc_o, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check_eq("t9_rst_perf_fetch", perf_fetch_o, 32'd0);
        check_eq("t9_rst_perf_stall", perf_stall_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
